// File: rtl/packet_framer_pkg.sv
// Shared definitions for the framing path: FSM states, confi field layout and
// counter widths. Also imported by data_packer.
package packet_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int CONFI_W   = 16;
    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 7;
    localparam int LEN_W     = LEN_MSB - LEN_LSB + 1;
    localparam int PKT_CNT_W = 16;

    function automatic logic [LEN_W-1:0] cfg_len(input logic [CONFI_W-1:0] confi);
        return confi[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/packet_framer_if.sv
// Byte stream bundle used on both sides of the framer.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are
// both 1; once tvalid is raised, tdata/tlast/tuser hold until that transfer.
interface packet_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/packet_framer.sv
// Cuts a raw byte stream into packets of L bytes, zero-padding the last packet
// (pad bytes flagged on tuser) when the stream ends early.
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CONFI_W-1:0]   confi,
    packet_framer_if.slave       s_axis,
    packet_framer_if.master      m_axis,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 cfg_err,
    output state_t               fsm_state
);

    state_t                state, state_nxt;
    logic [LEN_W-1:0]      len_r, len_nxt;
    logic [7:0]            byte_cnt, cnt_nxt;
    logic                  m_valid, valid_nxt;
    logic [DATA_WIDTH-1:0] m_data, data_nxt;
    logic                  m_last, last_nxt;
    logic                  m_user, user_nxt;
    logic                  out_ready;
    logic                  boundary;
    logic                  s_ready;
    logic [8:0]            unused_bits;

    assign unused_bits = {confi[15:8], s_axis.tuser};

    assign out_ready = !m_valid || m_axis.tready;
    assign boundary  = (byte_cnt == len_r - 8'd1);

    always_comb begin
        state_nxt = state;
        len_nxt   = len_r;
        cnt_nxt   = byte_cnt;
        // Without a new load the register drains when the consumer takes it.
        valid_nxt = m_valid && !m_axis.tready;
        data_nxt  = m_data;
        last_nxt  = m_last;
        user_nxt  = m_user;
        s_ready   = 1'b0;
        cfg_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_len(confi) != '0) begin
                    len_nxt   = cfg_len(confi);
                    cnt_nxt   = '0;
                    state_nxt = PASS;
                end else begin
                    cfg_err = 1'b1;
                end
            end
            PASS: begin
                s_ready = out_ready;
                if (s_axis.tvalid && out_ready) begin
                    valid_nxt = 1'b1;
                    data_nxt  = s_axis.tdata;
                    last_nxt  = boundary;
                    user_nxt  = 1'b0;
                    cnt_nxt   = boundary ? 8'd0 : byte_cnt + 8'd1;
                    if (s_axis.tlast) state_nxt = boundary ? IDLE : PAD;
                end
            end
            PAD: begin
                if (out_ready) begin
                    valid_nxt = 1'b1;
                    data_nxt  = '0;
                    last_nxt  = boundary;
                    user_nxt  = 1'b1;
                    cnt_nxt   = boundary ? 8'd0 : byte_cnt + 8'd1;
                    if (boundary) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_r    <= '0;
            byte_cnt <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_user   <= 1'b0;
        end else begin
            state    <= state_nxt;
            len_r    <= len_nxt;
            byte_cnt <= cnt_nxt;
            m_valid  <= valid_nxt;
            m_data   <= data_nxt;
            m_last   <= last_nxt;
            m_user   <= user_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (m_valid && m_axis.tready && m_last) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tlast  = m_last;
    assign m_axis.tuser  = m_user;
    assign fsm_state     = state;

endmodule

// File: tb/tb_packet_framer.sv
// Self-checking bench for packet_framer: scenario tasks feed byte streams and
// a scoreboard compares every output beat against a queue of expected beats.
module tb_packet_framer;
    import packet_framer_pkg::*;

    localparam int DW = 8;
    localparam int W  = DW + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [CONFI_W-1:0]   confi;
    logic [PKT_CNT_W-1:0] pkt_count;
    logic                 cfg_err;
    state_t               fsm_state;

    packet_framer_if #(.DATA_WIDTH(DW)) s_axis ();
    packet_framer_if #(.DATA_WIDTH(DW)) m_axis ();

    packet_framer #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .confi     (confi),
        .s_axis    (s_axis),
        .m_axis    (m_axis),
        .pkt_count (pkt_count),
        .cfg_err   (cfg_err),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic toggle_mode = 1'b0;

    // expected beat = {tuser, tlast, tdata}
    logic [W-1:0] exp_q[$];
    int model_len;
    int model_pos;

    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = toggle_mode ? ~m_axis.tready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Scoreboard and hold-while-stalled monitor.
    logic         stalled = 1'b0;
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] want;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            got = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
            if (stalled) begin
                total_cnt++;
                if (m_axis.tvalid !== 1'b1 || got !== held)
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             m_axis.tvalid, got, held);
                else pass_cnt++;
            end
            stalled = m_axis.tvalid && !m_axis.tready;
            held    = got;
            if (m_axis.tvalid && m_axis.tready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard: got unexpected beat %h, required no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL scoreboard: got beat %h, required %h", got, want);
                    else pass_cnt++;
                end
            end
        end
    end

    task automatic push_beat(input logic [DW-1:0] data, input logic user);
        logic last;
        last = (model_pos == model_len - 1);
        exp_q.push_back({user, last, data});
        model_pos = last ? 0 : model_pos + 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = 1'b0;
        exp_q.delete();
        model_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_stream(input int n, input logic [DW-1:0] base, input logic end_last,
                               input int cfg_after_first);
        logic ok;
        int guard;
        model_pos = 0;
        for (int i = 0; i < n; i++) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = base + DW'(i);
            s_axis.tlast  = end_last && (i == n - 1);
            guard = 0;
            do begin
                @(negedge clk);
                ok = s_axis.tready;
                @(posedge clk);
                #1;
                guard++;
            end while (!ok && guard < 200);
            total_cnt++;
            if (!ok) begin
                $display("FAIL input_accept: got no handshake for byte %0d, required handshake", i);
                break;
            end
            pass_cnt++;
            push_beat(base + DW'(i), 1'b0);
            if (i == 0 && cfg_after_first >= 0) confi = 16'(cfg_after_first);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        if (end_last) while (model_pos != 0) push_beat('0, 1'b1);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic check_pkts(input int want_pkts);
        total_cnt++;
        if (pkt_count !== PKT_CNT_W'(want_pkts))
            $display("FAIL pkt_count: got %0d, required %0d", pkt_count, want_pkts);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        confi = 16'hAB04;
        reset = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        total_cnt++;
        if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser} !== 3'b000 || m_axis.tdata !== '0)
            $display("FAIL reset_outputs: got v/l/u=%b%b%b data=%h, required 000 00",
                     m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tdata);
        else pass_cnt++;
        total_cnt++;
        if (pkt_count !== '0) $display("FAIL reset_pkt: got %0d, required 0", pkt_count);
        else pass_cnt++;
        total_cnt++;
        if (s_axis.tready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", s_axis.tready);
        else pass_cnt++;
        total_cnt++;
        if (fsm_state !== IDLE) $display("FAIL reset_state: got %0d, required %0d", fsm_state, IDLE);
        else pass_cnt++;
        total_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err_l4: got %b, required 0", cfg_err);
        else pass_cnt++;
        confi = 16'h0000;
        #1;
        total_cnt++;
        if (cfg_err !== 1'b1) $display("FAIL reset_cfg_err_l0: got %b, required 1", cfg_err);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_continuous();
        confi = 16'h0004;
        model_len = 4;
        apply_reset();
        send_stream(8, 8'h01, 1'b1, 0);
        wait_drain();
        check_pkts(2);
        total_cnt++;
        if (fsm_state !== IDLE || cfg_err !== 1'b1)
            $display("FAIL continuous_idle: got state=%0d cfg_err=%b, required %0d 1",
                     fsm_state, cfg_err, IDLE);
        else pass_cnt++;
    endtask

    task automatic test_pad();
        confi = 16'h0004;
        model_len = 4;
        apply_reset();
        send_stream(6, 8'h11, 1'b1, 0);
        wait_drain();
        check_pkts(2);
        total_cnt++;
        if (fsm_state !== IDLE)
            $display("FAIL pad_idle: got state=%0d, required %0d", fsm_state, IDLE);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        confi = 16'h0003;
        model_len = 3;
        apply_reset();
        toggle_mode = 1'b1;
        send_stream(9, 8'h31, 1'b1, -1);
        wait_drain();
        toggle_mode = 1'b0;
        check_pkts(3);
    endtask

    task automatic test_cfg_err();
        confi = 16'h0000;
        model_len = 2;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (s_axis.tready !== 1'b0 || cfg_err !== 1'b1)
                $display("FAIL cfg_err_hold: got ready=%b cfg_err=%b, required 0 1",
                         s_axis.tready, cfg_err);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        confi = 16'h0002;
        @(negedge clk);
        total_cnt++;
        if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear: got %b, required 0", cfg_err);
        else pass_cnt++;
        send_stream(4, 8'h41, 1'b1, -1);
        wait_drain();
        check_pkts(2);
    endtask

    task automatic test_reset_mid();
        confi = 16'h0005;
        model_len = 5;
        apply_reset();
        send_stream(2, 8'h51, 1'b0, -1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total_cnt++;
        if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser, s_axis.tready} !== 4'b0000 ||
            m_axis.tdata !== '0 || pkt_count !== '0 || fsm_state !== IDLE)
            $display("FAIL mid_reset: got v/l/u/rdy=%b%b%b%b data=%h pkt=%0d state=%0d, required 0000 00 0 %0d",
                     m_axis.tvalid, m_axis.tlast, m_axis.tuser, s_axis.tready,
                     m_axis.tdata, pkt_count, fsm_state, IDLE);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_stream(5, 8'h61, 1'b1, -1);
        wait_drain();
        check_pkts(1);
    endtask

    task automatic test_len1();
        confi = 16'h0001;
        model_len = 1;
        apply_reset();
        send_stream(3, 8'hA0, 1'b1, 8);
        wait_drain();
        check_pkts(3);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_pad();
        test_backpressure();
        test_cfg_err();
        test_reset_mid();
        test_len1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
